imuldiv_mul_arb2: RTL and testbench
===================================

IMULDIV_MUL_ARB2 -- requirements
Module: imuldiv_mul_arb2

Interface
REQ-001 SHALL have no parameters; all widths are fixed: operands 32 bits, result 64 bits.
REQ-002 SHALL have the following ports, one per line, clock and reset first:
  clk  input  1  single clock; all state updates on posedge clk
  reset  input  1  synchronous, active-high reset
  req0_msg_a  input  32  port-0 operand A
  req0_msg_b  input  32  port-0 operand B
  req0_val  input  1  port-0 request valid
  req0_rdy  output  1  port-0 request ready
  req1_msg_a  input  32  port-1 operand A
  req1_msg_b  input  32  port-1 operand B
  req1_val  input  1  port-1 request valid
  req1_rdy  output  1  port-1 request ready
  resp0_msg_result  output  64  port-0 product
  resp0_val  output  1  port-0 response valid
  resp0_rdy  input  1  port-0 response ready
  resp1_msg_result  output  64  port-1 product
  resp1_val  output  1  port-1 response valid
  resp1_rdy  input  1  port-1 response ready
  mulreq_msg_a  output  32  operand A to the shared iterative multiplier
  mulreq_msg_b  output  32  operand B to the shared multiplier
  mulreq_val  output  1  multiplier request valid
  mulreq_rdy  input  1  multiplier request ready
  mulresp_msg_result  input  64  multiplier product
  mulresp_val  input  1  multiplier response valid
  mulresp_rdy  output  1  multiplier response ready
  busy  output  1  high in any state other than IDLE
REQ-003 SHALL use one clock domain (clk), with reset synchronous and active-high.

Function
REQ-004 SHALL implement the FSM states IDLE, WAIT and RESP, with 1-bit owner, 1-bit last_grant and a 64-bit result_reg.
REQ-005 IDLE grant: if exactly one reqN_val is high, grant = that N; if both are high, grant = ~last_grant; if neither is high, no grant.
REQ-006 IDLE outputs:
  mulreq_val = granted reqN_val; mulreq_msg_a/b = granted operands (combinational).
  Granted reqN_rdy = mulreq_rdy; the non-granted rdy = 0.
  mulresp_rdy = 0.
REQ-007 IDLE transition: on mulreq_val && mulreq_rdy, owner <= grant, last_grant <= grant, state <= WAIT.
REQ-008 WAIT: mulresp_rdy = 1, req0_rdy = req1_rdy = 0, mulreq_val = 0; on mulresp_val, result_reg <= mulresp_msg_result and state <= RESP.
REQ-009 RESP: resp_owner_val = 1 and the other resp_val = 0; mulresp_rdy = 0 and both req rdy = 0; on resp_owner_rdy, state <= IDLE.
REQ-010 resp0_msg_result and resp1_msg_result SHALL both equal result_reg at all times; the value is passed through unmodified, with the sign handled by the multiplier.
REQ-011 SHALL allow at most one operation in flight; a new grant is possible no earlier than the cycle after the RESP handshake.
REQ-012 Latency: a request accepted in cycle t with the multiplier response in cycle t+k gives resp_val high from cycle t+k+1.
REQ-013 A response is held stable (val high, msg unchanged) under backpressure for any number of cycles.
REQ-014 A request deasserted before its handshake in IDLE SHALL NOT be recorded; the grant is re-evaluated every cycle in IDLE.
REQ-015 mulresp_val in IDLE or RESP SHALL be ignored, since mulresp_rdy = 0 in those states.
REQ-016 Under continuous valid on both ports, grants SHALL strictly alternate 0,1,0,1...; no port waits more than one other operation.

Reset
REQ-017 On reset: state = IDLE, owner = 0, last_grant = 1 (port 0 wins the first tie), result_reg = 0.
REQ-018 Outputs during reset: resp0_val = resp1_val = 0, mulresp_rdy = 0, busy = 0.
REQ-019 Reset asserted in WAIT or RESP SHALL abort the operation with no response issued; the shared multiplier is reset by the same reset signal.

Verification
REQ-020 Port-0 alone, a=3, b=0xFFFFFFFB (-5) -> resp0_val with resp0_msg_result = 0xFFFFFFFFFFFFFFF1; resp1_val stays 0.
REQ-021 Both ports valid in the first cycle after reset (p0: 7×6, p1: 0x10000×0x10000) -> port 0 served first with result 42, then port 1 with result 0x0000000100000000.
REQ-022 resp0_rdy held 0 for 5 cycles in RESP while req1_val = 1 -> resp0_val and result stay stable, req1_rdy = 0 and mulreq_val = 0 throughout; port 1 is granted in the IDLE cycle after the handshake.
REQ-023 Both ports continuously valid for 6 operations -> grant order 0,1,0,1,0,1; each product returned on the correct port.
REQ-024 Reset pulsed in the cycle after entering WAIT -> busy = 0 the next cycle, no resp_val ever asserted, and the next request completes normally.
REQ-025 mulreq_rdy held 0 for 3 cycles with req0_val = 1 -> req0_rdy = 0 and state stays IDLE; the handshake occurs in the first cycle mulreq_rdy = 1.

Source files
------------

// File: rtl/imuldiv_mul_arb2.sv
// imuldiv_mul_arb2: round-robin arbiter sharing one iterative multiplier between two request/response ports
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   req0_*/req1_*                operand requests (val/rdy) from the two clients
//   resp0_*/resp1_*              64-bit products back to the owning client (val/rdy)
//   mulreq_*/mulresp_*           request/response channel to the shared multiplier
//   busy                         high whenever an operation is in flight
module imuldiv_mul_arb2 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [63:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [63:0] result_q, result_d;
  logic        grant, idle;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end
  // A tie goes to the port that did not win last; otherwise the lone requester wins.
  always_comb begin
    idle         = state_q == IDLE;
    grant        = (req0_val && req1_val) ? ~last_grant_q : req1_val;
    mulreq_val   = idle && (req0_val || req1_val);
    mulreq_msg_a = grant ? req1_msg_a : req0_msg_a;
    mulreq_msg_b = grant ? req1_msg_b : req0_msg_b;
    req0_rdy     = idle && !grant && mulreq_rdy;
    req1_rdy     = idle && grant && mulreq_rdy;
    mulresp_rdy  = state_q == WAIT;
    resp0_val    = state_q == RESP && !owner_q;
    resp1_val    = state_q == RESP && owner_q;
    busy         = !idle;
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    unique case (state_q)
      IDLE: if (mulreq_val && mulreq_rdy) begin
        owner_d      = grant;
        last_grant_d = grant;
        state_d      = WAIT;
      end
      WAIT: if (mulresp_val) begin
        result_d = mulresp_msg_result;
        state_d  = RESP;
      end
      RESP: state_d = (owner_q ? resp1_rdy : resp0_rdy) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  assign resp0_msg_result = result_q;
  assign resp1_msg_result = result_q;
endmodule

// File: tb/tb_imuldiv_mul_arb2.sv
// tb_imuldiv_mul_arb2: directed bench for the two-port multiplier arbiter with a behavioural multiplier
module tb_imuldiv_mul_arb2;
  logic        clk = 0, reset = 1;
  logic [31:0] req0_msg_a = 0, req0_msg_b = 0, req1_msg_a = 0, req1_msg_b = 0;
  logic        req0_val = 0, req1_val = 0, req0_rdy, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        resp0_val, resp1_val, resp0_rdy = 1, resp1_rdy = 1;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy, mulresp_val, mulresp_rdy, busy;
  logic [63:0] mulresp_msg_result;
  logic        m_busy = 0, m_rdy_en = 1;
  logic [2:0]  m_cnt = 0;
  logic [63:0] m_res = 0;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  imuldiv_mul_arb2 dut (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
    .busy(busy)
  );
  // Shared multiplier stand-in: signed product, response three cycles after acceptance.
  assign mulreq_rdy         = m_rdy_en && !m_busy;
  assign mulresp_val        = m_busy && m_cnt == 0;
  assign mulresp_msg_result = m_res;
  always @(posedge clk) begin
    if (reset) m_busy <= 0;
    else if (mulreq_val && mulreq_rdy) begin
      m_busy <= 1;
      m_cnt  <= 2;
      m_res  <= $signed({{32{mulreq_msg_a[31]}}, mulreq_msg_a}) * $signed({{32{mulreq_msg_b[31]}}, mulreq_msg_b});
    end else if (m_busy && m_cnt != 0) m_cnt <= m_cnt - 1;
    else if (mulresp_val && mulresp_rdy) m_busy <= 0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_resp(input bit p, output int n);
    n = 0;
    while (!(p ? resp1_val : resp0_val) && n < 20) begin
      step;
      n++;
    end
    if (n >= 20) chk("resp_timeout", 0, 1);
  endtask
  int n;
  initial begin
    step;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_resp0_val", resp0_val, 0);
    chk("rst_resp1_val", resp1_val, 0);
    chk("rst_mulresp_rdy", mulresp_rdy, 0);
    chk("rst_result", resp0_msg_result, 0);
    reset = 0;
    req0_msg_a = 3; req0_msg_b = 32'hFFFFFFFB; req0_val = 1;
    #1;
    chk("t1_mulreq_val", mulreq_val, 1);
    chk("t1_req0_rdy", req0_rdy, 1);
    chk("t1_req1_rdy", req1_rdy, 0);
    chk("t1_mulreq_a", mulreq_msg_a, 3);
    step;
    req0_val = 0;
    #1;
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_mulresp_rdy", mulresp_rdy, 1);
    chk("t1_wait_req0_rdy", req0_rdy, 0);
    wait_resp(0, n);
    chk("t1_latency", n, 3);
    chk("t1_result", resp0_msg_result, 64'hFFFFFFFFFFFFFFF1);
    chk("t1_resp1_val", resp1_val, 0);
    step;
    chk("t1_done_busy", busy, 0);
    reset = 1;
    step;
    reset = 0;
    req0_msg_a = 7; req0_msg_b = 6; req0_val = 1;
    req1_msg_a = 32'h10000; req1_msg_b = 32'h10000; req1_val = 1;
    #1;
    chk("t2_req0_rdy", req0_rdy, 1);
    chk("t2_req1_rdy", req1_rdy, 0);
    chk("t2_mulreq_a", mulreq_msg_a, 7);
    step;
    req0_val = 0;
    wait_resp(0, n);
    chk("t2_res0", resp0_msg_result, 42);
    chk("t2_resp1_idle", resp1_val, 0);
    step;
    chk("t2_req1_rdy_next", req1_rdy, 1);
    chk("t2_mulreq_a1", mulreq_msg_a, 32'h10000);
    step;
    req1_val = 0;
    wait_resp(1, n);
    chk("t2_res1", resp1_msg_result, 64'h0000000100000000);
    chk("t2_resp0_idle", resp0_val, 0);
    step;
    resp0_rdy = 0;
    req0_msg_a = 2; req0_msg_b = 3; req0_val = 1;
    step;
    req0_val = 0;
    req1_msg_a = 4; req1_msg_b = 5; req1_val = 1;
    wait_resp(0, n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_val", resp0_val, 1);
      chk("t3_hold_res", resp0_msg_result, 6);
      chk("t3_hold_req1_rdy", req1_rdy, 0);
      chk("t3_hold_mulreq_val", mulreq_val, 0);
      step;
    end
    resp0_rdy = 1;
    step;
    chk("t3_req1_granted", req1_rdy, 1);
    chk("t3_mulreq_a", mulreq_msg_a, 4);
    step;
    req1_val = 0;
    wait_resp(1, n);
    chk("t3_res1", resp1_msg_result, 20);
    step;
    req0_val = 1; req1_val = 1;
    for (int i = 0; i < 6; i++) begin
      req0_msg_a = 10 + i; req0_msg_b = 3;
      req1_msg_a = 20 + i; req1_msg_b = 3;
      #1;
      chk("t4_grant", req1_rdy, i % 2);
      chk("t4_grant_n", req0_rdy, 1 - i % 2);
      step;
      wait_resp(i % 2, n);
      chk("t4_res", resp0_msg_result, (i % 2) ? 20 + i * 3 + 40 : 30 + i * 3);
      chk("t4_other_val", (i % 2) ? resp0_val : resp1_val, 0);
      step;
    end
    req0_val = 0; req1_val = 0;
    req0_msg_a = 9; req0_msg_b = 9; req0_val = 1;
    step;
    req0_val = 0;
    step;
    reset = 1;
    step;
    reset = 0;
    chk("t5_busy_after_rst", busy, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_resp", resp0_val | resp1_val, 0);
      step;
    end
    req0_val = 1;
    step;
    req0_val = 0;
    wait_resp(0, n);
    chk("t5_res", resp0_msg_result, 81);
    step;
    m_rdy_en = 0;
    req0_msg_a = 5; req0_msg_b = 5; req0_val = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_req0_rdy_low", req0_rdy, 0);
      chk("t6_busy_low", busy, 0);
      chk("t6_mulreq_val", mulreq_val, 1);
      step;
    end
    m_rdy_en = 1;
    #1;
    chk("t6_req0_rdy_high", req0_rdy, 1);
    step;
    req0_val = 0;
    chk("t6_busy", busy, 1);
    wait_resp(0, n);
    chk("t6_res", resp0_msg_result, 25);
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
